bus_xfer_seq: RTL and testbench
===============================

Name: bus_xfer_seq

Overview:
Sequencer for the reading end of the shared 32-bit tristate data bus. Register blocks drive the bus when their N_OE is low and load on their clock. bus_xfer_seq performs one source-to-destination transfer per request:
- enables exactly one source driver
- waits for the bus to settle
- strobes the destination load enable and captures the bus value
- releases the bus with a turnaround gap so two drivers never overlap

Parameters:
NUM_SRC, 6, number of bus driver registers (width of N_OE)
NUM_DST, 6, number of destination registers (width of LOAD)
SEL_W, 3, width of SRC_SEL/DST_SEL; must satisfy 2**SEL_W >= NUM_SRC and >= NUM_DST
SETTLE_CYCLES, 1, cycles the driver is enabled before capture (>=1)
TURN_CYCLES, 1, cycles with all drivers off after capture (>=1)

Ports:
CLK  in  1  single system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ  in  1  transfer request; sampled only in IDLE
SRC_SEL  in  SEL_W  index of source register to drive the bus
DST_SEL  in  SEL_W  index of destination register to load
BUS  in  32  shared tristate data bus, as seen at the reader
N_OE  out  NUM_SRC  active-low output enables to the source registers
LOAD  out  NUM_DST  active-high, one-cycle load strobes to destinations
DATA  out  32  last captured bus value
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle pulse when a transfer completes
ERR  out  1  one-cycle pulse on a rejected (out-of-range) request

Interface decision: one clock (CLK); reset (RST) is synchronous and active-high.

Behaviour:
- All outputs are registered.
- Reset values: N_OE all ones, LOAD 0, DATA 0, BUSY 0, DONE 0, ERR 0; state IDLE.
- States and transitions:
  - IDLE: BUSY=0.
    - REQ=1 with SRC_SEL<NUM_SRC and DST_SEL<NUM_DST: latch both selects, go to DRIVE, counter <= SETTLE_CYCLES.
    - REQ=1 with either select out of range: stay IDLE, ERR=1 next cycle, no N_OE/LOAD activity.
  - DRIVE: N_OE[src]=0 and all other N_OE bits 1. Decrement counter; go to CAPTURE when it reaches 1.
  - CAPTURE (exactly 1 cycle): N_OE[src] still 0, LOAD[dst]=1. DATA <= BUS at the closing edge. Go to TURN, counter <= TURN_CYCLES.
  - TURN: N_OE all 1, LOAD 0. Decrement counter; go to IDLE with DONE=1 when it reaches 1.
- Latency for request accepted at cycle T (defaults):
  - T+1 DRIVE
  - T+2 CAPTURE (LOAD high)
  - T+3 TURN (DATA valid)
  - T+4 IDLE with DONE=1
  - General case: DONE at T+2+SETTLE_CYCLES+TURN_CYCLES.
- Back-to-back: REQ in the DONE cycle is accepted (that cycle is IDLE). The next N_OE enable therefore follows at least TURN_CYCLES+1 cycles after the previous release.
- REQ while BUSY: ignored, not queued. SRC_SEL/DST_SEL changes during a transfer have no effect.
- SRC_SEL == DST_SEL index is legal; the two select spaces are independent.
- RST at any state, including mid-DRIVE or CAPTURE:
  - next cycle is IDLE with reset values; N_OE releases at that edge
  - no DONE pulse; DATA cleared
  - REQ coincident with RST is ignored
- Invariants:
  - at most one N_OE bit low in any cycle
  - LOAD is zero or one-hot, and high only while the matching transfer's N_OE bit is low
  - DONE, ERR and LOAD are each exactly one cycle wide
  - DONE and ERR are never high together

Decomposition:
- In the common include (common.v):
  - state encoding constants: IDLE, DRIVE, CAPTURE, TURN
  - bus width constant BUS_W=32
- One sub-module, onehot_decode_n:
  - parameterized index-to-one-hot decoder with enable and output polarity select
  - instantiated twice: active-low for N_OE, active-high for LOAD

Test Plan:
- Reset then idle: RST for 2 cycles, REQ=0 -> N_OE=6'b111111, LOAD=0, DATA=0, BUSY=0 throughout.
- Basic transfer: SRC_SEL=2, DST_SEL=5, BUS=32'hDEADBEEF, REQ pulse at T -> N_OE=6'b111011 at T+1..T+2, LOAD=6'b100000 at T+2 only, DATA=32'hDEADBEEF from T+3, DONE at T+4, BUSY at T+1..T+3.
- Back-to-back: second REQ (SRC=0, DST=1, BUS=32'h00000001) in the DONE cycle -> N_OE all ones for at least 2 cycles between the two enables, second DONE 4 cycles later, DATA=1.
- Out-of-range: SRC_SEL=7 with REQ -> ERR pulse at T+1, N_OE stays all ones, LOAD 0, BUSY 0, no DONE.
- Reset mid-transfer: RST asserted during CAPTURE -> next cycle N_OE all ones, LOAD 0, DATA 0, no DONE; a following REQ completes normally.
- Parameter sweep: SETTLE_CYCLES=3, TURN_CYCLES=2 -> LOAD at T+4, DONE at T+7; a REQ pulsed during BUSY produces no extra transfer.

Source files
------------

// File: rtl/bus_xfer_seq_pkg.sv
// Shared definitions for the bus transfer sequencer: state encoding, bus width
// and the select range check used when a request is accepted.
package bus_xfer_seq_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        TURN    = 2'd3
    } state_t;

    function automatic logic sel_in_range(input int sel, input int limit);
        return sel < limit;
    endfunction

endpackage

// File: rtl/bus_xfer_seq_decode.sv
// Index-to-one-hot decoder with enable; ACTIVE_LOW inverts the result so the
// same block can produce active-low output enables or active-high strobes.
module onehot_decode_n #(
    parameter int N          = 6,
    parameter int IDX_W      = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     dec
);

    logic [N-1:0] hot;

    always_comb begin
        hot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                hot[i] = 1'b1;
            end
        end
    end

    assign dec = ACTIVE_LOW ? ~hot : hot;

endmodule

// File: rtl/bus_xfer_seq.sv
// Reader-side sequencer for the shared tristate bus: enables one source driver,
// lets the bus settle, strobes the destination load, then leaves a turnaround gap.
module bus_xfer_seq
    import bus_xfer_seq_pkg::*;
#(
    parameter int NUM_SRC       = 6,
    parameter int NUM_DST       = 6,
    parameter int SEL_W         = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ,
    input  logic [SEL_W-1:0]   SRC_SEL,
    input  logic [SEL_W-1:0]   DST_SEL,
    input  logic [BUS_W-1:0]   BUS,
    output logic [NUM_SRC-1:0] N_OE,
    output logic [NUM_DST-1:0] LOAD,
    output logic [BUS_W-1:0]   DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR
);

    localparam int MAX_CNT = (SETTLE_CYCLES > TURN_CYCLES) ? SETTLE_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t             state;
    logic [SEL_W-1:0]   src_q;
    logic [SEL_W-1:0]   dst_q;
    logic [CNT_W-1:0]   cnt;

    logic               sel_ok;
    logic               oe_en;
    logic               ld_en;
    logic [SEL_W-1:0]   oe_idx;
    logic [NUM_SRC-1:0] n_oe_d;
    logic [NUM_DST-1:0] load_d;

    assign sel_ok = sel_in_range(int'(SRC_SEL), NUM_SRC) && sel_in_range(int'(DST_SEL), NUM_DST);

    // Decoder inputs describe the next cycle so N_OE and LOAD can be registered
    // without lagging the state by a cycle.
    assign oe_en  = ((state == IDLE) && REQ && sel_ok) || (state == DRIVE);
    assign oe_idx = (state == IDLE) ? SRC_SEL : src_q;
    assign ld_en  = (state == DRIVE) && (cnt == CNT_W'(1));

    onehot_decode_n #(
        .N          (NUM_SRC),
        .IDX_W      (SEL_W),
        .ACTIVE_LOW (1'b1)
    ) u_oe_dec (
        .en  (oe_en),
        .idx (oe_idx),
        .dec (n_oe_d)
    );

    onehot_decode_n #(
        .N          (NUM_DST),
        .IDX_W      (SEL_W),
        .ACTIVE_LOW (1'b0)
    ) u_load_dec (
        .en  (ld_en),
        .idx (dst_q),
        .dec (load_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt   <= '0;
            N_OE  <= '1;
            LOAD  <= '0;
            DATA  <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            N_OE <= n_oe_d;
            LOAD <= load_d;
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        if (sel_ok) begin
                            src_q <= SRC_SEL;
                            dst_q <= DST_SEL;
                            cnt   <= CNT_W'(SETTLE_CYCLES);
                            state <= DRIVE;
                            BUSY  <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    DATA  <= BUS;
                    cnt   <= CNT_W'(TURN_CYCLES);
                    state <= TURN;
                end
                TURN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Self-checking bench for bus_xfer_seq: a default instance and a slow-timing
// instance, with a scoreboard of accepted transfers checked at LOAD and DONE.
module tb_bus_xfer_seq;

    typedef struct packed {
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        armed = 1'b0;

    logic        req_a, req_b;
    logic [2:0]  src_a, dst_a, src_b, dst_b;
    logic [31:0] bus_a, bus_b;
    logic [5:0]  n_oe_a, load_a, n_oe_b, load_b;
    logic [31:0] data_a, data_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    xfer_t       sb_a[$];
    xfer_t       sb_b[$];
    xfer_t       pop_a, pop_b;
    logic [5:0]  exp_ld_a, exp_oe_a, exp_ld_b, exp_oe_b;

    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    bus_xfer_seq u_dut (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req_a),
        .SRC_SEL (src_a),
        .DST_SEL (dst_a),
        .BUS     (bus_a),
        .N_OE    (n_oe_a),
        .LOAD    (load_a),
        .DATA    (data_a),
        .BUSY    (busy_a),
        .DONE    (done_a),
        .ERR     (err_a)
    );

    bus_xfer_seq #(
        .SETTLE_CYCLES (3),
        .TURN_CYCLES   (2)
    ) u_dut_sweep (
        .CLK     (clk),
        .RST     (rst),
        .REQ     (req_b),
        .SRC_SEL (src_b),
        .DST_SEL (dst_b),
        .BUS     (bus_b),
        .N_OE    (n_oe_b),
        .LOAD    (load_b),
        .DATA    (data_b),
        .BUSY    (busy_b),
        .DONE    (done_b),
        .ERR     (err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkState(input string tag, input logic [5:0] noe, input logic [5:0] ld,
                              input logic bsy, input logic dn);
        checkOutput({tag, "_noe"}, 32'(n_oe_a), 32'(noe));
        checkOutput({tag, "_load"}, 32'(load_a), 32'(ld));
        checkOutput({tag, "_busy"}, 32'(busy_a), 32'(bsy));
        checkOutput({tag, "_done"}, 32'(done_a), 32'(dn));
    endtask

    task automatic applyStimulus(input logic [2:0] src, input logic [2:0] dst,
                                 input logic [31:0] data, input bit accept);
        xfer_t e;
        req_a = 1'b1;
        src_a = src;
        dst_a = dst;
        if (accept) begin
            e.src  = src;
            e.dst  = dst;
            e.data = data;
            sb_a.push_back(e);
        end
    endtask

    // Scoreboard for the default instance plus bus-safety invariants every cycle.
    always @(negedge clk) begin
        if (armed) begin
            if (load_a != 6'd0) begin
                if (sb_a.size() == 0) begin
                    checkOutput("sb_a_load_unexpected", 32'(load_a), 32'd0);
                end else begin
                    exp_ld_a = 6'd1 << sb_a[0].dst;
                    exp_oe_a = ~(6'd1 << sb_a[0].src);
                    checkOutput("sb_a_load", 32'(load_a), 32'(exp_ld_a));
                    checkOutput("sb_a_noe_at_load", 32'(n_oe_a), 32'(exp_oe_a));
                end
            end
            if (done_a) begin
                if (sb_a.size() == 0) begin
                    checkOutput("sb_a_done_unexpected", 32'(done_a), 32'd0);
                end else begin
                    pop_a = sb_a.pop_front();
                    checkOutput("sb_a_data", data_a, pop_a.data);
                end
            end
            checkOutput("inv_a_onecold", 32'($countones(~n_oe_a) <= 1), 32'd1);
            checkOutput("inv_a_done_err", 32'(done_a & err_a), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (load_b != 6'd0) begin
                if (sb_b.size() == 0) begin
                    checkOutput("sb_b_load_unexpected", 32'(load_b), 32'd0);
                end else begin
                    exp_ld_b = 6'd1 << sb_b[0].dst;
                    exp_oe_b = ~(6'd1 << sb_b[0].src);
                    checkOutput("sb_b_load", 32'(load_b), 32'(exp_ld_b));
                    checkOutput("sb_b_noe_at_load", 32'(n_oe_b), 32'(exp_oe_b));
                end
            end
            if (done_b) begin
                if (sb_b.size() == 0) begin
                    checkOutput("sb_b_done_unexpected", 32'(done_b), 32'd0);
                end else begin
                    pop_b = sb_b.pop_front();
                    checkOutput("sb_b_data", data_b, pop_b.data);
                end
            end
            checkOutput("inv_b_err", 32'(err_b), 32'd0);
        end
    end

    initial begin
        rst   = 1'b1;
        req_a = 1'b0; src_a = 3'd0; dst_a = 3'd0; bus_a = 32'h0;
        req_b = 1'b0; src_b = 3'd0; dst_b = 3'd0; bus_b = 32'h0;

        repeat (2) begin
            @(negedge clk);
            checkState("reset", 6'h3f, 6'h00, 1'b0, 1'b0);
            checkOutput("reset_data", data_a, 32'h0);
        end
        armed = 1'b1;
        rst   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkState("idle", 6'h3f, 6'h00, 1'b0, 1'b0);
            checkOutput("idle_data", data_a, 32'h0);
        end

        // Basic transfer; BUS only carries the real value during the capture cycle
        applyStimulus(3'd2, 3'd5, 32'hDEADBEEF, 1'b1);
        bus_a = 32'h11111111;
        @(negedge clk);
        req_a = 1'b0; src_a = 3'd0; dst_a = 3'd0;
        checkState("basic_t1", 6'b111011, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkState("basic_t2", 6'b111011, 6'b100000, 1'b1, 1'b0);
        bus_a = 32'hDEADBEEF;
        @(negedge clk);
        checkState("basic_t3", 6'h3f, 6'h00, 1'b1, 1'b0);
        checkOutput("basic_t3_data", data_a, 32'hDEADBEEF);
        bus_a = 32'h22222222;
        @(negedge clk);
        checkState("basic_t4", 6'h3f, 6'h00, 1'b0, 1'b1);
        checkOutput("basic_t4_data", data_a, 32'hDEADBEEF);

        // Back-to-back request issued in the DONE cycle
        applyStimulus(3'd0, 3'd1, 32'h00000001, 1'b1);
        @(negedge clk);
        req_a = 1'b0;
        checkState("b2b_t1", 6'b111110, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkState("b2b_t2", 6'b111110, 6'b000010, 1'b1, 1'b0);
        bus_a = 32'h00000001;
        @(negedge clk);
        checkState("b2b_t3", 6'h3f, 6'h00, 1'b1, 1'b0);
        bus_a = 32'h33333333;
        @(negedge clk);
        checkState("b2b_t4", 6'h3f, 6'h00, 1'b0, 1'b1);
        checkOutput("b2b_data", data_a, 32'h00000001);
        @(negedge clk);
        checkState("b2b_t5", 6'h3f, 6'h00, 1'b0, 1'b0);

        // Out-of-range selects on either side
        applyStimulus(3'd7, 3'd0, 32'h0, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        checkState("oor_src_t1", 6'h3f, 6'h00, 1'b0, 1'b0);
        checkOutput("oor_src_err", 32'(err_a), 32'd1);
        @(negedge clk);
        checkOutput("oor_src_err_width", 32'(err_a), 32'd0);
        applyStimulus(3'd1, 3'd6, 32'h0, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        checkState("oor_dst_t1", 6'h3f, 6'h00, 1'b0, 1'b0);
        checkOutput("oor_dst_err", 32'(err_a), 32'd1);
        @(negedge clk);
        checkOutput("oor_dst_err_width", 32'(err_a), 32'd0);

        // Reset during CAPTURE, with a request held alongside reset
        applyStimulus(3'd4, 3'd3, 32'hCAFEF00D, 1'b1);
        bus_a = 32'hCAFEF00D;
        @(negedge clk);
        req_a = 1'b0;
        checkState("rstmid_t1", 6'b101111, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkState("rstmid_t2", 6'b101111, 6'b001000, 1'b1, 1'b0);
        rst = 1'b1; req_a = 1'b1; src_a = 3'd0; dst_a = 3'd0;
        @(negedge clk);
        sb_a.delete();
        checkState("rstmid_t3", 6'h3f, 6'h00, 1'b0, 1'b0);
        checkOutput("rstmid_data", data_a, 32'h0);
        @(negedge clk);
        checkState("rstmid_t4", 6'h3f, 6'h00, 1'b0, 1'b0);
        rst = 1'b0; req_a = 1'b0;
        @(negedge clk);
        checkState("rstmid_t5", 6'h3f, 6'h00, 1'b0, 1'b0);

        applyStimulus(3'd5, 3'd0, 32'h0BADCAFE, 1'b1);
        bus_a = 32'h44444444;
        @(negedge clk);
        req_a = 1'b0;
        checkState("recover_t1", 6'b011111, 6'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkState("recover_t2", 6'b011111, 6'b000001, 1'b1, 1'b0);
        bus_a = 32'h0BADCAFE;
        @(negedge clk);
        bus_a = 32'h55555555;
        @(negedge clk);
        checkState("recover_t4", 6'h3f, 6'h00, 1'b0, 1'b1);
        checkOutput("recover_data", data_a, 32'h0BADCAFE);

        // Slow-timing instance: SETTLE=3, TURN=2; REQ during BUSY must be dropped
        begin
            xfer_t e;
            e.src = 3'd3; e.dst = 3'd2; e.data = 32'hA5A5C3C3;
            sb_b.push_back(e);
        end
        req_b = 1'b1; src_b = 3'd3; dst_b = 3'd2; bus_b = 32'h66666666;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("sweep_t%0d_noe", k), 32'(n_oe_b),
                        (k >= 1 && k <= 4) ? 32'h37 : 32'h3f);
            checkOutput($sformatf("sweep_t%0d_load", k), 32'(load_b),
                        (k == 4) ? 32'h04 : 32'h00);
            checkOutput($sformatf("sweep_t%0d_busy", k), 32'(busy_b),
                        (k >= 1 && k <= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("sweep_t%0d_done", k), 32'(done_b),
                        (k == 7) ? 32'd1 : 32'd0);
            req_b = (k == 2) ? 1'b1 : 1'b0;
            src_b = (k == 2) ? 3'd0 : src_b;
            dst_b = (k == 2) ? 3'd0 : dst_b;
            bus_b = (k == 4) ? 32'hA5A5C3C3 : 32'h77777777;
        end
        checkOutput("sweep_data", data_b, 32'hA5A5C3C3);

        repeat (3) @(negedge clk);
        checkOutput("sb_a_drained", 32'(sb_a.size()), 32'd0);
        checkOutput("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
